// File: rtl/stim_pattern_driver_pkg.sv
// Shared types and default widths for the stimulus pattern driver.
// Pure declarations: no latency, no flow control.
package stim_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } stim_state_t;

    localparam int STIM_PAT_W_DEF = 8;
    localparam int STIM_CNT_W_DEF = 8;

endpackage

// File: rtl/stim_pattern_driver_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
// Latency: one clock from inc/clr to q; no backpressure, saturates at all-ones.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/stim_pattern_driver.sv
// Shifts a captured pattern onto signal_out LSB first and scores the checker's match/fail replies.
// Latency: first bit one cycle after the start edge, done PAT_W+1 cycles later; start ignored while busy.
// Mismatch detection on error is compiled in only when STIM_CHECK_EN is defined; otherwise error is 0.
module stim_pattern_driver
    import stim_pkg::*;
#(
    parameter int PAT_W = STIM_PAT_W_DEF,
    parameter int CNT_W = STIM_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic             match_in,
    input  logic             fail_in,
    output logic             signal_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] match_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             error
);

    localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;

    stim_state_t      state;
    logic [PAT_W-1:0] shreg;
    logic [IDX_W-1:0] idx;
    logic             sample_vld;
    logic             clr;

    assign clr = (state == IDLE) && start;

    // Outputs are registered from the state, so the visible run trails the
    // internal FSM by one cycle; sample_vld marks cycles where signal_out is live.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            shreg      <= '0;
            idx        <= '0;
            signal_out <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            sample_vld <= 1'b0;
        end else begin
            signal_out <= 1'b0;
            done       <= 1'b0;
            busy       <= (state != IDLE);
            sample_vld <= (state == DRIVE);
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg <= pattern;
                        idx   <= '0;
                        state <= DRIVE;
                    end
                end
                DRIVE: begin
                    signal_out <= shreg[0];
                    shreg      <= shreg >> 1;
                    idx        <= idx + IDX_W'(1);
                    if (idx == IDX_W'(PAT_W - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_match_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (sample_vld && match_in),
        .q   (match_cnt)
    );

    sat_counter #(.W(CNT_W)) u_fail_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (sample_vld && fail_in),
        .q   (fail_cnt)
    );

`ifdef STIM_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            error <= 1'b0;
        end else if (clr) begin
            error <= 1'b0;
        end else if (sample_vld && ((match_in != signal_out) || (fail_in != !signal_out))) begin
            error <= 1'b1;
        end
    end
`else
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_stim_pattern_driver.sv
// Bench for stim_pattern_driver: behavioural checker loopback plus per-run reference model.
module tb_stim_pattern_driver;

    localparam int PAT_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [PAT_W-1:0] pattern = '0;
    int               mode = 0;

    logic             match1, fail1, so1, busy1, done1, err1;
    logic [7:0]       mcnt1, fcnt1;
    logic             match2, fail2, so2, busy2, done2, err2;
    logic [1:0]       mcnt2, fcnt2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Checker behaviours: 0 correct, 1 match stuck 0, 2 inverted, 3 both high, 4 both low.
    function automatic logic [1:0] chk(input int md, input logic s);
        case (md)
            1:       return {1'b0, !s};
            2:       return {!s, s};
            3:       return 2'b11;
            4:       return 2'b00;
            default: return {s, !s};
        endcase
    endfunction

    always_comb {match1, fail1} = chk(mode, so1);
    always_comb {match2, fail2} = chk(mode, so2);

    stim_pattern_driver #(.PAT_W(PAT_W), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .pattern(pattern),
        .match_in(match1), .fail_in(fail1), .signal_out(so1), .busy(busy1),
        .done(done1), .match_cnt(mcnt1), .fail_cnt(fcnt1), .error(err1)
    );

    stim_pattern_driver #(.PAT_W(PAT_W), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .start(start), .pattern(pattern),
        .match_in(match2), .fail_in(fail2), .signal_out(so2), .busy(busy2),
        .done(done2), .match_cnt(mcnt2), .fail_cnt(fcnt2), .error(err2)
    );

    function automatic int sat3(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    task automatic model(input logic [7:0] p, input int md,
                         output int em, output int ef, output logic ee);
        logic [1:0] r;
        em = 0; ef = 0; ee = 1'b0;
        for (int k = 0; k < PAT_W; k++) begin
            r  = chk(md, p[k]);
            em += int'(r[1]);
            ef += int'(r[0]);
            if (r != {p[k], !p[k]}) ee = 1'b1;
        end
`ifndef STIM_CHECK_EN
        ee = 1'b0;
`endif
    endtask

    task automatic run(input logic [7:0] p, input int md, input int restart_at, input string nm);
        int em, ef, dcnt, dcyc, k, bcyc;
        logic ee;
        logic [7:0] got;
        model(p, md, em, ef, ee);
        mode = md;
        @(negedge clk);
        pattern = p;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0; dcnt = 0; dcyc = -1; bcyc = 0; got = '0;
        for (int c = 1; c <= PAT_W + 4; c++) begin
            @(negedge clk);
            if (c == 1) begin
                total++;
                if (mcnt1 !== 8'd0 || fcnt1 !== 8'd0 || err1 !== 1'b0) begin
                    bad++;
                    $display("FAIL %s clear_on_start: got m=%0d f=%0d e=%0b want 0 0 0", nm, mcnt1, fcnt1, err1);
                end
            end
            if (busy1) bcyc++;
            if (busy1 && !done1 && k < PAT_W) begin
                got[k] = so1;
                k++;
            end
            if (done1) begin
                dcnt++;
                dcyc = c;
                total++;
                if (mcnt1 !== 8'(em) || fcnt1 !== 8'(ef) || err1 !== ee) begin
                    bad++;
                    $display("FAIL %s counts: got m=%0d f=%0d e=%0b want m=%0d f=%0d e=%0b",
                             nm, mcnt1, fcnt1, err1, em, ef, ee);
                end
                total++;
                if (mcnt2 !== 2'(sat3(em)) || fcnt2 !== 2'(sat3(ef)) || done2 !== 1'b1) begin
                    bad++;
                    $display("FAIL %s sat_counts: got m=%0d f=%0d d=%0b want m=%0d f=%0d d=1",
                             nm, mcnt2, fcnt2, done2, sat3(em), sat3(ef));
                end
            end
            start = (c == restart_at);
        end
        start = 1'b0;
        total++;
        if (got !== p) begin
            bad++;
            $display("FAIL %s bit_seq: got %b want %b (LSB first)", nm, got, p);
        end
        total++;
        if (dcnt != 1 || dcyc != PAT_W + 1) begin
            bad++;
            $display("FAIL %s done_timing: got count=%0d cycle=%0d want count=1 cycle=%0d", nm, dcnt, dcyc, PAT_W + 1);
        end
        total++;
        if (bcyc != PAT_W + 1) begin
            bad++;
            $display("FAIL %s busy_len: got %0d want %0d", nm, bcyc, PAT_W + 1);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++;
        if ({so1, busy1, done1, err1, mcnt1, fcnt1, mcnt2, fcnt2} !== '0) begin
            bad++;
            $display("FAIL reset_values: got so=%0b busy=%0b done=%0b err=%0b m=%0d f=%0d want all 0",
                     so1, busy1, done1, err1, mcnt1, fcnt1);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_patterns();
        run(8'hA5, 0, -1, "a5_ok");
        run(8'hFF, 0, -1, "ff_ok");
    endtask

    task automatic test_stuck_match();
        logic ee_want;
`ifdef STIM_CHECK_EN
        ee_want = 1'b1;
`else
        ee_want = 1'b0;
`endif
        run(8'h0F, 1, -1, "0f_stuck");
        repeat (3) @(negedge clk);
        total++;
        if (err1 !== ee_want || mcnt1 !== 8'd0 || fcnt1 !== 8'd4) begin
            bad++;
            $display("FAIL stuck_hold: got e=%0b m=%0d f=%0d want e=%0b m=0 f=4", err1, mcnt1, fcnt1, ee_want);
        end
    endtask

    task automatic test_restart_ignored();
        run(8'h3C, 0, 3, "restart_ignored");
    endtask

    task automatic test_mid_reset();
        mode = 0;
        @(negedge clk);
        pattern = 8'hA5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if ({so1, busy1, done1, err1, mcnt1, fcnt1, mcnt2, fcnt2} !== '0) begin
            bad++;
            $display("FAIL mid_reset: got so=%0b busy=%0b done=%0b err=%0b m=%0d f=%0d want all 0",
                     so1, busy1, done1, err1, mcnt1, fcnt1);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (busy1 !== 1'b0 || so1 !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_idle: got busy=%0b so=%0b want 0 0", busy1, so1);
        end
        run(8'h01, 0, -1, "post_reset_01");
    endtask

    task automatic test_random();
        logic [7:0] p;
        int md;
        for (int i = 0; i < 20; i++) begin
            p  = 8'($urandom);
            md = int'($urandom_range(0, 4));
            run(p, md, -1, "random");
        end
    endtask

    task automatic test_back_to_back();
        int em, ef, dones, cyc;
        logic ee;
        logic [7:0] p;
        p = 8'($urandom);
        model(p, 0, em, ef, ee);
        mode = 0;
        @(negedge clk);
        pattern = p;
        start = 1'b1;
        dones = 0;
        cyc = 0;
        while (dones < 2 && cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (done1) begin
                dones++;
                total++;
                if (mcnt1 !== 8'(em) || fcnt1 !== 8'(ef)) begin
                    bad++;
                    $display("FAIL held_start_counts: got m=%0d f=%0d want m=%0d f=%0d", mcnt1, fcnt1, em, ef);
                end
            end
        end
        start = 1'b0;
        total++;
        if (dones != 2) begin
            bad++;
            $display("FAIL held_start_retrigger: got %0d done pulses in %0d cycles want 2", dones, cyc);
        end
        repeat (PAT_W + 4) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_patterns();
        test_stuck_match();
        test_restart_ignored();
        test_mid_reset();
        test_random();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
